stash_arbiter: RTL

STASH_ARBITER -- requirements
Module: stash_arbiter

---
 rtl/stash_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/stash_arbiter.sv
// stash_arbiter
// Arbitrates three write sources (manual button, split capture, periodic
// auto-log) and a read-pointer advance request onto a single stash port.
// Every access is a one-cycle strobe followed by GAP_CYCLES idle cycles.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   req_manual      : pulse, write time_reading
//   req_split       : pulse, write split_time
//   auto_en         : level, enables the periodic auto-log timer
//   count_enabled   : level, auto timer advances only while high
//   time_reading    : 8-bit {dasec, sec}
//   split_time      : 8-bit captured split value
//   req_next        : pulse, request a stash read-pointer advance
//   stash_data      : write data, holds the last granted value
//   stash_valid     : one-cycle write strobe
//   stash_next      : one-cycle read-advance strobe
//   pending         : pending write flags {auto, split, manual}
//   drop_count      : saturating count of dropped write requests
//   busy            : high while an access or its gap is in progress
module stash_arbiter #(
  parameter int AUTO_PERIOD = 100000000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_manual,
  input  logic       req_split,
  input  logic       auto_en,
  input  logic       count_enabled,
  input  logic [7:0] time_reading,
  input  logic [7:0] split_time,
  input  logic       req_next,
  output logic [7:0] stash_data,
  output logic       stash_valid,
  output logic       stash_next,
  output logic [2:0] pending,
  output logic [7:0] drop_count,
  output logic       busy
);

  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]   auto_cnt_q, auto_cnt_d;
  logic [2:0]      pend_q, pend_d;
  logic            next_pend_q, next_pend_d;
  logic [1:0]      rr_q, rr_d;
  logic [2:0][7:0] data_q, data_d;
  logic [1:0]      grant_idx_q, grant_idx_d;
  logic [7:0]      stash_data_q, stash_data_d;
  logic            valid_q, valid_d;
  logic            next_q, next_d;
  logic [7:0]      drop_q, drop_d;

  logic            auto_req;
  logic [2:0]      pulse;
  logic [2:0][7:0] src_data;
  logic [2:0]      granted_mask;
  logic [2:0]      drop;
  logic [1:0]      n_drop;
  logic [8:0]      drop_sum;
  logic [1:0]      sel;

  // First pending source after 'last' in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    idx     = last;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Auto-log timer and request capture
  always_comb begin
    auto_req   = 1'b0;
    auto_cnt_d = auto_cnt_q;
    if (!auto_en) begin
      auto_cnt_d = '0;
    end else if (count_enabled) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_cnt_d = '0;
        auto_req   = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end

    pulse       = {auto_req, req_split, req_manual};
    src_data[0] = time_reading;
    src_data[1] = split_time;
    src_data[2] = time_reading;

    // A source being written this cycle may re-arm without counting a drop.
    granted_mask = (state_q == GRANT && valid_q) ? (3'b001 << grant_idx_q) : 3'b000;

    drop   = '0;
    pend_d = pend_q & ~granted_mask;
    data_d = data_q;
    for (int s = 0; s < 3; s++) begin
      if (pulse[s]) begin
        if (pend_q[s] && !granted_mask[s]) begin
          drop[s] = 1'b1;
        end else begin
          pend_d[s] = 1'b1;
          data_d[s] = src_data[s];
        end
      end
    end

    n_drop   = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    drop_sum = {1'b0, drop_q} + {7'b0, n_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    next_pend_d = next_pend_q;
    if (state_q == GRANT && next_q) begin
      next_pend_d = 1'b0;
    end else if (req_next) begin
      next_pend_d = 1'b1;
    end
  end

  // Arbitration FSM
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    valid_d      = 1'b0;
    next_d       = 1'b0;
    grant_idx_d  = grant_idx_q;
    rr_d         = rr_q;
    stash_data_d = stash_data_q;
    sel          = rr_pick(pend_q, rr_q);
    case (state_q)
      IDLE: begin
        if (next_pend_q) begin
          state_d = GRANT;
          next_d  = 1'b1;
        end else if (|pend_q) begin
          state_d      = GRANT;
          valid_d      = 1'b1;
          grant_idx_d  = sel;
          // Data is captured here so a same-source pulse during GRANT
          // cannot change the value being written.
          stash_data_d = data_q[sel];
        end
      end
      GRANT: begin
        if (valid_q) rr_d = grant_idx_q;
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      auto_cnt_q   <= '0;
      pend_q       <= '0;
      next_pend_q  <= 1'b0;
      rr_q         <= 2'd2;
      data_q       <= '0;
      grant_idx_q  <= '0;
      stash_data_q <= '0;
      valid_q      <= 1'b0;
      next_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      auto_cnt_q   <= auto_cnt_d;
      pend_q       <= pend_d;
      next_pend_q  <= next_pend_d;
      rr_q         <= rr_d;
      data_q       <= data_d;
      grant_idx_q  <= grant_idx_d;
      stash_data_q <= stash_data_d;
      valid_q      <= valid_d;
      next_q       <= next_d;
      drop_q       <= drop_d;
    end
  end

  // Strobes are masked by reset so an aborted access never reaches the stash.
  assign stash_valid = valid_q & ~reset;
  assign stash_next  = next_q & ~reset;
  assign stash_data  = stash_data_q;
  assign pending     = pend_q;
  assign drop_count  = drop_q;
  assign busy        = (state_q != IDLE);

endmodule
